// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory port of the fetch stage: request/address out, ready/data back.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    // Fetch unit side: issues requests, consumes returned words.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    // Memory side: observes requests, returns words.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory port,
// loads the IF/ID register and applies branch/jump redirects from decode.
// A one-entry skid buffer parks a word that returns while decode is stalled.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   branch,
    input  logic                   bne,
    input  logic                   alu_zero,
    input  logic                   jump,
    input  logic [31:0]            redir_pc4,
    input  logic [31:0]            branch_offset,
    input  logic [25:0]            jump_index,
    pc_fetch_unit_if.master        imem,
    output logic [31:0]            if_id_instr,
    output logic [31:0]            if_id_pc4,
    output logic                   if_id_valid,
    output logic [31:0]            pc
);

    // S_FETCH: request outstanding; S_HELD: word parked in skid buffer.
    typedef enum logic {
        S_FETCH = 1'b0,
        S_HELD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;

    logic        take_br;
    logic        redirect;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] redir_target;
    logic [31:0] pc_plus4;

    // bne flips the sense of the zero test; jump wins over a taken branch.
    assign take_br       = branch & (alu_zero ^ bne);
    assign redirect      = jump | take_br;
    assign jump_target   = {redir_pc4[31:28], jump_index, 2'b00};
    assign branch_target = redir_pc4 + {branch_offset[29:0], 2'b00};
    assign redir_target  = jump ? jump_target : branch_target;
    assign pc_plus4      = pc_q + 32'd4;

    // Next-state: redirect > stall > normal flow; reset is applied in the register block.
    always_comb begin
        // NOTE: every variable gets a hold default first so no path can infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc4_d     = pc4_q;
        valid_d   = valid_q;
        buf_d     = buf_q;
        buf_pc4_d = buf_pc4_q;

        if (redirect) begin
            // Any word returning this cycle belongs to the wrong path and is dropped.
            pc_d    = redir_target;
            valid_d = 1'b0;
            state_d = S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (imem.imem_ready) begin
                        pc_d = pc_plus4;
                        if (stall) begin
                            buf_d     = imem.imem_rdata;
                            buf_pc4_d = pc_plus4;
                            state_d   = S_HELD;
                        end else begin
                            instr_d = imem.imem_rdata;
                            pc4_d   = pc_plus4;
                            valid_d = 1'b1;
                        end
                    end else if (!stall) begin
                        // Nothing arrived: insert a bubble, keep stale payload.
                        valid_d = 1'b0;
                    end
                end
                S_HELD: begin
                    if (!stall) begin
                        instr_d = buf_q;
                        pc4_d   = buf_pc4_q;
                        valid_d = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            pc4_q     <= '0;
            valid_q   <= 1'b0;
            // NOTE: the skid buffer is a plain register, so it is cleared like the rest;
            // a stale parked word can then never resurface after reset.
            buf_q     <= '0;
            buf_pc4_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc4_q     <= pc4_d;
            valid_q   <= valid_d;
            buf_q     <= buf_d;
            buf_pc4_q <= buf_pc4_d;
        end
    end

    // Request only while fetching and out of reset; address is the PC itself.
    assign imem.imem_req  = (state_q == S_FETCH) & rst_n;
    assign imem.imem_addr = pc_q;

    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: each stimulus step pushes the expected
// post-edge state into a queue; a monitor pops and compares on the falling edge.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        bne = 1'b0;
    logic        alu_zero = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] redir_pc4 = '0;
    logic [31:0] branch_offset = '0;
    logic [25:0] jump_index = '0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] pc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] pc;
        logic        req;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    pc_fetch_unit_if mem ();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch        (branch),
        .bne           (bne),
        .alu_zero      (alu_zero),
        .jump          (jump),
        .redir_pc4     (redir_pc4),
        .branch_offset (branch_offset),
        .jump_index    (jump_index),
        .imem          (mem.master),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .pc            (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares the DUT against the oldest expectation each falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
            check({e.tag, ".instr"}, if_id_instr, e.instr);
            check({e.tag, ".pc4"},   if_id_pc4,   e.pc4);
            check({e.tag, ".pc"},    pc,          e.pc);
            check({e.tag, ".addr"},  mem.imem_addr, e.pc);
            check({e.tag, ".req"},   {31'd0, mem.imem_req}, {31'd0, e.req});
        end
    end

    // Set decoder redirect inputs for the next step only.
    task automatic redir(input logic br, input logic bn, input logic z, input logic j,
                         input logic [31:0] rpc4, input logic [31:0] off, input logic [25:0] jidx);
        branch = br; bne = bn; alu_zero = z; jump = j;
        redir_pc4 = rpc4; branch_offset = off; jump_index = jidx;
    endtask

    // One clock: drive inputs, then record the state expected after the edge.
    task automatic step(input string tag, input logic r, input logic s, input logic rdy,
                        input logic [31:0] rd, input logic ev, input logic [31:0] ei,
                        input logic [31:0] ep4, input logic [31:0] epc, input logic ereq);
        exp_t e;
        @(negedge clk);
        #1;
        rst_n = r; stall = s; mem.imem_ready = rdy; mem.imem_rdata = rd;
        @(posedge clk);
        e.valid = ev; e.instr = ei; e.pc4 = ep4; e.pc = epc; e.req = ereq; e.tag = tag;
        exp_q.push_back(e);
        #1;
        redir(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem.imem_ready = 1'b0;
        mem.imem_rdata = '0;

        //     tag        rst st rdy rdata         valid instr         pc4           pc            req
        step("rst0",     0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0);
        step("rst1",     0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0);

        // Zero-wait fetch stream.
        step("fetch0",   1, 0, 1, 32'h2008_0005, 1, 32'h2008_0005, 32'h4,      32'h4,        1);
        step("fetch1",   1, 0, 1, 32'h8C09_0004, 1, 32'h8C09_0004, 32'h8,      32'h8,        1);

        // Stall on arrival: word parked, no requests for three cycles.
        step("stall0",   1, 1, 1, 32'hAAAA_0001, 1, 32'h8C09_0004, 32'h8,      32'hC,        0);
        step("stall1",   1, 1, 0, 32'h0,        1, 32'h8C09_0004, 32'h8,      32'hC,        0);
        step("stall2",   1, 1, 0, 32'h0,        1, 32'h8C09_0004, 32'h8,      32'hC,        0);
        step("release",  1, 0, 0, 32'h0,        1, 32'hAAAA_0001, 32'hC,      32'hC,        1);
        step("bubble",   1, 0, 0, 32'h0,        0, 32'hAAAA_0001, 32'hC,      32'hC,        1);
        step("refetch",  1, 0, 1, 32'h0000_0011, 1, 32'h0000_0011, 32'h10,     32'h10,       1);

        // beq taken: 0x10 + (-2 << 2) = 0x08; returning word dropped.
        redir(1, 0, 1, 0, 32'h10, 32'hFFFF_FFFE, 26'h0);
        step("beq_tk",   1, 0, 1, 32'hDEAD_BEEF, 0, 32'h0000_0011, 32'h10,     32'h8,        1);
        // Same inputs with bne=1: condition inverted, no redirect.
        redir(1, 1, 1, 0, 32'h10, 32'hFFFF_FFFE, 26'h0);
        step("beq_nt",   1, 0, 1, 32'h0000_0022, 1, 32'h0000_0022, 32'hC,      32'hC,        1);

        // Jump: {A, 0x40, 00} = 0xA000_0100.
        redir(0, 0, 0, 1, 32'hA000_0010, 32'h0, 26'h000_0040);
        step("jump",     1, 0, 0, 32'h0,        0, 32'h0000_0022, 32'hC,      32'hA000_0100, 1);
        // Jump and taken branch together: jump target 0x200 beats branch 0x30.
        redir(1, 0, 1, 1, 32'h20, 32'h4, 26'h000_0080);
        step("jmp_pri",  1, 0, 0, 32'h0,        0, 32'h0000_0022, 32'hC,      32'h200,      1);

        // Redirect while held with stall high: parked word discarded.
        step("h_fetch",  1, 0, 1, 32'h3333_0001, 1, 32'h3333_0001, 32'h204,    32'h204,      1);
        step("h_park",   1, 1, 1, 32'h4444_0002, 1, 32'h3333_0001, 32'h204,    32'h208,      0);
        redir(0, 0, 0, 1, 32'h300, 32'h0, 26'h000_0010);
        step("h_redir",  1, 1, 0, 32'h0,        0, 32'h3333_0001, 32'h204,    32'h40,       1);
        step("h_after",  1, 0, 1, 32'h5555_0003, 1, 32'h5555_0003, 32'h44,     32'h44,       1);

        // Reset in the middle of a wait.
        step("w_bub",    1, 0, 0, 32'h0,        0, 32'h5555_0003, 32'h44,     32'h44,       1);
        step("w_rst0",   0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0);
        step("w_rst1",   0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0);
        step("w_restart",1, 0, 1, 32'h6666_0004, 1, 32'h6666_0004, 32'h4,      32'h4,        1);

        // PC wrap: jump to 0xFFFF_FFFC then fetch once.
        redir(0, 0, 0, 1, 32'hF000_0000, 32'h0, 26'h3FF_FFFF);
        step("wrap_j",   1, 0, 0, 32'h0,        0, 32'h6666_0004, 32'h4,      32'hFFFF_FFFC, 1);
        step("wrap",     1, 0, 1, 32'h7777_0005, 1, 32'h7777_0005, 32'h0,      32'h0,        1);

        // bne taken (zero=0): 0x100 + (3 << 2) = 0x10C.
        redir(1, 1, 0, 0, 32'h100, 32'h3, 26'h0);
        step("bne_tk",   1, 0, 0, 32'h0,        0, 32'h7777_0005, 32'h0,      32'h10C,      1);
        // beq not taken (zero=0, bne=0).
        redir(1, 0, 0, 0, 32'h100, 32'h3, 26'h0);
        step("beq_nt2",  1, 0, 1, 32'h8888_0006, 1, 32'h8888_0006, 32'h110,    32'h110,      1);
        // Stall with no data in S_FETCH: IF/ID held, request stays up.
        step("st_wait",  1, 1, 0, 32'h0,        1, 32'h8888_0006, 32'h110,    32'h110,      1);

        @(negedge clk);
        #2;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
